// File: rtl/pbit_sweep.sv
// rtl/pbit_sweep.sv - sequential p-bit sweep controller driving an external energy-delta encoder
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle run request, honoured only while idle
//   init_state, n_sweeps   run setup, captured with an accepted start
//   noise_mask             mask applied to the LFSR draw (noise build only)
//   enc_state, enc_index   current state and one-hot flip index to the encoder
//   enc_delta              encoder result: energy change if the indexed bit flips
//   busy, done             run in progress / one-cycle completion pulse
//   energy                 running sum of accepted deltas for the current run
//
// Build option: PBIT_SWEEP_NOISE_EN selects noisy acceptance; otherwise greedy.

module pbit_sweep #(
    parameter int          PBITS     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PBITS-1:0]    init_state,
    input  logic [15:0]         n_sweeps,
    input  logic [15:0]         noise_mask,
    output logic [PBITS-1:0]    enc_state,
    output logic [PBITS-1:0]    enc_index,
    input  logic signed [31:0]  enc_delta,
    output logic                busy,
    output logic                done,
    output logic signed [31:0]  energy
);

    localparam int              KW     = (PBITS > 1) ? $clog2(PBITS) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(PBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PROPOSE,
        S_DECIDE,
        S_FINISH
    } fsm_t;

    fsm_t                fsm_q;
    fsm_t                fsm_d;
    logic [PBITS-1:0]    state_q;
    logic [KW-1:0]       k_q;
    logic [15:0]         sweep_q;
    logic signed [31:0]  delta_q;
    logic signed [31:0]  energy_q;
    logic [PBITS-1:0]    onehot;
    logic                accept;
    logic                last_bit;

    assign onehot   = PBITS'(1) << k_q;
    assign last_bit = (k_q == K_LAST);

`ifdef PBIT_SWEEP_NOISE_EN
    logic [15:0] lfsr_q;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right; one step per decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (fsm_q == S_DECIDE) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Noise is zero-extended, so the compare is signed against a non-negative value.
    assign accept = (delta_q < $signed({16'b0, lfsr_q & noise_mask}));
`else
    logic unused_noise;
    assign unused_noise = ^{noise_mask, LFSR_SEED};

    // Strictly downhill only; a zero delta is rejected.
    assign accept = delta_q[31];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:    if (start) fsm_d = S_LOAD;
            S_LOAD:    fsm_d = (sweep_q == 16'd0) ? S_FINISH : S_PROPOSE;
            S_PROPOSE: fsm_d = S_DECIDE;
            // Last bit of the last sweep: the counter is about to reach zero.
            S_DECIDE:  fsm_d = (last_bit && sweep_q == 16'd1) ? S_FINISH : S_PROPOSE;
            S_FINISH:  fsm_d = S_IDLE;
            default:   fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '0;
            k_q      <= '0;
            sweep_q  <= 16'd0;
            delta_q  <= 32'sd0;
            energy_q <= 32'sd0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= init_state;
                        sweep_q  <= n_sweeps;
                        energy_q <= 32'sd0;
                    end
                end
                S_LOAD: begin
                    k_q <= '0;
                end
                S_PROPOSE: begin
                    delta_q <= enc_delta;
                end
                S_DECIDE: begin
                    // Committing here means the next bit's proposal sees this flip.
                    if (accept) begin
                        state_q  <= state_q ^ onehot;
                        energy_q <= energy_q + delta_q;
                    end
                    if (last_bit) begin
                        k_q     <= '0;
                        sweep_q <= sweep_q - 16'd1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign enc_state = state_q;
    assign enc_index = (fsm_q == S_PROPOSE || fsm_q == S_DECIDE) ? onehot : '0;
    assign busy      = (fsm_q == S_LOAD || fsm_q == S_PROPOSE || fsm_q == S_DECIDE);
    assign done      = (fsm_q == S_FINISH);
    assign energy    = energy_q;

endmodule

// File: tb/tb_pbit_sweep.sv
// tb/tb_pbit_sweep.sv - self-checking bench for pbit_sweep with a behavioural encoder and sweep model

module tb_pbit_sweep;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [7:0]         init_state;
    logic [15:0]        n_sweeps;
    logic [15:0]        noise_mask;
    logic [7:0]         enc_state;
    logic [7:0]         enc_index;
    logic signed [31:0] enc_delta;
    logic               busy;
    logic               done;
    logic signed [31:0] energy;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;
    int h[8];
    logic [7:0]  trace[$];
    logic [31:0] etrace[$];

    pbit_sweep #(.PBITS(8), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .init_state (init_state),
        .n_sweeps   (n_sweeps),
        .noise_mask (noise_mask),
        .enc_state  (enc_state),
        .enc_index  (enc_index),
        .enc_delta  (enc_delta),
        .busy       (busy),
        .done       (done),
        .energy     (energy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [31:0] delta_fn(input logic [7:0] st, input int k, input int md, input int hk);
        case (md)
            0:       return (k % 2 == 0) ? -32'sd3 : 32'sd5;
            1:       return 32'sd0;
            2:       return 32'sh80000000;
            default: return 32'((st[k] ? -hk : hk) + (st[(k + 1) % 8] ? 2 : -2));
        endcase
    endfunction

    // Behavioural encoder sitting downstream of the DUT.
    always_comb begin
        enc_delta = 32'sd0;
        for (int i = 0; i < 8; i++)
            if (enc_index == (8'd1 << i)) enc_delta = delta_fn(enc_state, i, mode, h[i]);
    end

    // Reference: visit bits in order, commit each strictly downhill flip immediately.
    function automatic void model(input logic [7:0] init, input int s, output logic [7:0] st, output logic signed [31:0] e);
        logic signed [31:0] d;
        st = init;
        e  = 32'sd0;
        for (int sw = 0; sw < s; sw++)
            for (int k = 0; k < 8; k++) begin
                d = delta_fn(st, k, mode, h[k]);
                if (d < 0) begin
                    st[k] = ~st[k];
                    e     = e + d;
                end
            end
    endfunction

    // Launches a run from IDLE, returns cycles from the start edge to done, then the idle-held result.
    task automatic do_run(input logic [7:0] init, input int s, output int cyc, output logic [7:0] st, output logic signed [31:0] e);
        int limit;
        limit      = 2 + 16 * s + 20;
        init_state = init;
        n_sweeps   = 16'(s);
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        trace.delete();
        etrace.delete();
        trace.push_back(enc_index);
        etrace.push_back(energy);
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            trace.push_back(enc_index);
            etrace.push_back(energy);
        end
        @(negedge clk);
        st = enc_state;
        e  = energy;
    endtask

    task automatic randomize_field();
        for (int i = 0; i < 8; i++) h[i] = int'($urandom_range(40)) - 20;
    endtask

    task automatic test_reset();
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        init_state = 8'h00;
        n_sweeps = 16'd0;
        noise_mask = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({busy, done, enc_index, enc_state, energy} !== 50'd0) $display("FAIL reset_outputs: got %h want 0", {busy, done, enc_index, enc_state, energy}); else n_pass++;

        mode = 3;
        randomize_field();
        init_state = 8'hA5;
        n_sweeps = 16'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL busy_mid_run: got %b want 1", busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_reset_busy_done: got %b%b want 00", busy, done); else n_pass++;
        n_checks++; if (enc_index !== 8'h00) $display("FAIL mid_reset_index: got %h want 00", enc_index); else n_pass++;
        n_checks++; if (enc_state !== 8'h00) $display("FAIL mid_reset_state: got %h want 00", enc_state); else n_pass++;
        n_checks++; if (energy !== 32'sd0) $display("FAIL mid_reset_energy: got %0d want 0", energy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++; if (dones !== 0) $display("FAIL mid_reset_no_done: got %0d pulses want 0", dones); else n_pass++;
    endtask

    task automatic test_zero_sweeps();
        int cyc;
        logic [7:0] st;
        logic signed [31:0] e;
        logic [7:0] any_idx;
        mode = 0;
        do_run(8'h5A, 0, cyc, st, e);
        any_idx = 8'h00;
        foreach (trace[i]) any_idx = any_idx | trace[i];
        n_checks++; if (cyc !== 2) $display("FAIL s0_latency: got %0d want 2", cyc); else n_pass++;
        n_checks++; if (st !== 8'h5A) $display("FAIL s0_state: got %h want 5a", st); else n_pass++;
        n_checks++; if (e !== 32'sd0) $display("FAIL s0_energy: got %0d want 0", e); else n_pass++;
        n_checks++; if (any_idx !== 8'h00) $display("FAIL s0_index: got %h want 00", any_idx); else n_pass++;
    endtask

    task automatic test_greedy_pattern();
        int cyc;
        int bad;
        logic [7:0] st;
        logic [7:0] want;
        logic signed [31:0] e;
        mode = 0;
        do_run(8'h00, 1, cyc, st, e);
        n_checks++; if (cyc !== 18) $display("FAIL greedy_latency: got %0d want 18", cyc); else n_pass++;
        n_checks++; if (st !== 8'h55) $display("FAIL greedy_state: got %h want 55", st); else n_pass++;
        n_checks++; if (e !== -32'sd12) $display("FAIL greedy_energy: got %0d want -12", e); else n_pass++;
        bad = 0;
        if (trace.size() != 18) bad++;
        else begin
            if (trace[0] !== 8'h00 || trace[17] !== 8'h00) bad++;
            for (int j = 0; j < 16; j++) begin
                want = 8'd1 << (j / 2);
                if (trace[1 + j] !== want) bad++;
            end
        end
        n_checks++; if (bad !== 0) $display("FAIL greedy_index_seq: got %0d bad entries want 0", bad); else n_pass++;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL greedy_idle_after: got done=%b busy=%b want 0 0", done, busy); else n_pass++;
    endtask

    task automatic test_zero_delta();
        int cyc;
        logic [7:0] init;
        logic [7:0] st;
        logic signed [31:0] e;
        mode = 1;
        init = 8'($urandom);
        do_run(init, 2, cyc, st, e);
        n_checks++; if (cyc !== 34) $display("FAIL zero_delta_latency: got %0d want 34", cyc); else n_pass++;
        n_checks++; if (st !== init) $display("FAIL zero_delta_state: got %h want %h", st, init); else n_pass++;
        n_checks++; if (e !== 32'sd0) $display("FAIL zero_delta_energy: got %0d want 0", e); else n_pass++;
    endtask

    task automatic test_energy_wrap();
        int cyc;
        logic [7:0] st;
        logic signed [31:0] e;
        mode = 2;
        do_run(8'h00, 1, cyc, st, e);
        n_checks++; if (etrace.size() < 7 || etrace[4] !== 32'h80000000) $display("FAIL wrap_after_one: got %h want 80000000", (etrace.size() > 4) ? etrace[4] : 32'hx); else n_pass++;
        n_checks++; if (etrace.size() < 7 || etrace[6] !== 32'h00000000) $display("FAIL wrap_after_two: got %h want 00000000", (etrace.size() > 6) ? etrace[6] : 32'hx); else n_pass++;
        n_checks++; if (e !== 32'sd0) $display("FAIL wrap_energy: got %0d want 0", e); else n_pass++;
        n_checks++; if (st !== 8'hFF) $display("FAIL wrap_state: got %h want ff", st); else n_pass++;
    endtask

    task automatic test_random();
        int cyc;
        int s;
        logic [7:0] init;
        logic [7:0] st;
        logic [7:0] exp_st;
        logic signed [31:0] e;
        logic signed [31:0] exp_e;
        mode = 3;
        for (int r = 0; r < 6; r++) begin
            randomize_field();
            init = 8'($urandom);
            s    = int'($urandom_range(3));
            model(init, s, exp_st, exp_e);
            do_run(init, s, cyc, st, e);
            n_checks++; if (cyc !== 2 + 16 * s) $display("FAIL rand%0d_latency: got %0d want %0d", r, cyc, 2 + 16 * s); else n_pass++;
            n_checks++; if (st !== exp_st || e !== exp_e) $display("FAIL rand%0d_result: got %h/%0d want %h/%0d", r, st, e, exp_st, exp_e); else n_pass++;
        end
    endtask

    task automatic test_busy_protect();
        int cyc;
        int dones;
        int dcyc;
        logic [7:0] a;
        logic [7:0] exp_st;
        logic signed [31:0] exp_e;
        mode = 3;
        randomize_field();
        a = 8'($urandom);
        model(a, 2, exp_st, exp_e);
        init_state = a;
        n_sweeps = 16'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        dones = 0;
        dcyc = 0;
        repeat (45) begin
            @(negedge clk);
            cyc++;
            init_state = ~a;
            n_sweeps = 16'd5;
            if (done) begin
                dones++;
                if (dcyc == 0) dcyc = cyc;
                start = 1'b1;
            end else begin
                start = (cyc == 7);
            end
        end
        start = 1'b0;
        n_checks++; if (dones !== 1) $display("FAIL busy_done_count: got %0d want 1", dones); else n_pass++;
        n_checks++; if (dcyc !== 34) $display("FAIL busy_done_cycle: got %0d want 34", dcyc); else n_pass++;
        n_checks++; if (enc_state !== exp_st || energy !== exp_e) $display("FAIL busy_result: got %h/%0d want %h/%0d", enc_state, energy, exp_st, exp_e); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] init;
        logic [7:0] st;
        logic [7:0] exp_st;
        logic signed [31:0] e;
        logic signed [31:0] exp_e;
        mode = 3;
        for (int r = 0; r < 2; r++) begin
            randomize_field();
            init = 8'($urandom);
            model(init, 1, exp_st, exp_e);
            do_run(init, 1, cyc, st, e);
            n_checks++; if (cyc !== 18) $display("FAIL b2b%0d_latency: got %0d want 18", r, cyc); else n_pass++;
            n_checks++; if (st !== exp_st || e !== exp_e) $display("FAIL b2b%0d_result: got %h/%0d want %h/%0d", r, st, e, exp_st, exp_e); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) h[i] = 0;
        test_reset();
        test_zero_sweeps();
        test_greedy_pattern();
        test_zero_delta();
        test_energy_wrap();
        test_random();
        test_busy_protect();
        @(negedge clk);
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pbit_sweep.md
# pbit_sweep

Sequential sweep controller that owns the p-bit state register and drives the combinational energy-delta encoder directly downstream of it. It walks a one-hot flip index across all PBITS bits, registers the encoder's signed delta, and decides whether to commit each flip. Acceptance is greedy, or noisy when the noise option is compiled in. It repeats for a programmed number of sweeps and reports the final state and the accumulated energy change.

## Interface
Parameters:
- `PBITS`, 8: p-bit state width; must match the encoder's `PBITS`.
- `LFSR_SEED`, 16'hACE1: nonzero reset value of the noise LFSR.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE.
- `init_state`  in  PBITS  state loaded on an accepted `start`.
- `n_sweeps`  in  16  number of full sweeps to run; sampled with `start`.
- `noise_mask`  in  16  AND-mask applied to the LFSR to form the noise value; ignored without the noise option.
- `enc_state`  out  PBITS  current state register; connects to the encoder `state` input.
- `enc_index`  out  PBITS  one-hot flip index; connects to the encoder `index` input.
- `enc_delta`  in  32 signed  encoder output: energy change if the indexed bit flips.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the run completes.
- `energy`  out  32 signed  running sum of accepted deltas for the current run.

## Operation
- FSM states: IDLE, LOAD, PROPOSE, DECIDE, FINISH.
- IDLE: `start` high -> latch `init_state` into the state register. Latch `n_sweeps` into the sweep counter, clear `energy`, set `busy`, go to LOAD.
- LOAD: bit pointer k=0. If the sweep counter is 0 -> FINISH. Otherwise -> PROPOSE.
- PROPOSE: `enc_index` = 1<<k. The encoder settles combinationally, and `enc_delta` is registered into `delta_q` at the end of the cycle. -> DECIDE.
- DECIDE: `enc_index` is still 1<<k. Evaluate the accept rule on `delta_q`. The LFSR advances by one step.
  - On accept: state[k] inverts, and `energy` += `delta_q` (two's-complement wrap modulo 2^32, no saturation).
  - If k < PBITS-1: k+1, go to PROPOSE.
  - If k = PBITS-1: sweep counter -1, k=0. If the counter becomes 0 go to FINISH, otherwise go to PROPOSE.
- FINISH: `done`=1 for exactly this cycle, `busy` cleared. -> IDLE.
- `enc_index` = 0 in IDLE, LOAD and FINISH.
- `start` while busy is ignored. `init_state` and `n_sweeps` changes while busy have no effect.
- Bits are visited in order 0..PBITS-1 each sweep. The state is updated sequentially, so bit k+1 sees the committed value of bit k.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances only in DECIDE and is not reset by `start`, only by `rst_n`.

## Timing
- Reset (async assert, sync release) values:
  - FSM = IDLE.
  - State register = 0, so `enc_state` = 0.
  - `enc_index` = 0, `busy` = 0, `done` = 0, `energy` = 0.
  - `delta_q` = 0, k = 0, sweep counter = 0, LFSR = `LFSR_SEED`.
- Latency: `start` at edge t -> `busy` high after t. A run of S>0 sweeps raises `done` in cycle t+2+2·PBITS·S; S=0 raises `done` in cycle t+2.
- Each bit visit costs exactly 2 cycles. The encoder path is one full cycle, PROPOSE to `delta_q`.
- `start` coincident with FINISH is ignored. Any new `start` must arrive in IDLE, at the earliest the cycle after `done`.
- `rst_n` low mid-run aborts immediately to reset values. No `done` is issued.
- `energy` and `enc_state` hold their final values in IDLE until the next accepted `start`.

## Configuration
- `PBIT_SWEEP_NOISE_EN` defined: accept iff `delta_q` < {16'b0, LFSR & `noise_mask`}, a signed compare against a non-negative noise value. With `noise_mask`=0 this reduces to greedy.
- Not defined: greedy only; accept iff `delta_q` < 0. Delta = 0 is rejected. The LFSR and `noise_mask` logic are absent, and `noise_mask` is unused.

## Test plan
- Reset: `rst_n` low mid-run → `busy`=0, `done`=0, `enc_index`=0, `enc_state`=0, `energy`=0 asynchronously; no `done` pulse.
- S=0: PBITS=8, `start` with `n_sweeps`=0, `init_state`=8'h5A → `done` two cycles later. `enc_state`=8'h5A, `energy`=0, and `enc_index` never nonzero.
- Greedy sweep: PBITS=8, delta model returns -3 for even k and +5 for odd k, `init_state`=0, S=1 → `done` at t+18, `enc_state`=8'h55, `energy`=-12. The `enc_index` sequence is 01,01,02,02,…,80,80.
- Zero delta: delta model always 0, S=2, macro undefined → `enc_state` unchanged and `energy`=0. With the macro and `noise_mask`=16'hFFFF, flips occur on every LFSR draw >0.
- Busy protection: second `start` with a different `init_state` mid-run, plus `start` on the FINISH cycle → both ignored, a single `done` pulse, and the result matches the first run.
- Energy wrap: delta model always -2^31, all flips accepted, PBITS=8, S=1 → `energy` wraps to 0 after 2 accepts and ends at 0.
